queue_enq_arbiter: RTL and testbench

- Shares one circular_q instance (enqueue side) between NUM_REQ producers using round-robin arbitration.
- Gates the consumer's dequeue request against a shadow occupancy count.
- Sequences a one-cycle flush of the queue.
- Sits between issue-side producers (e.g. decode lanes) and the instruction/ROB queue.
- The queue is never driven with an enqueue it would drop, or a dequeue on empty.

---
 rtl/queue_enq_arbiter.sv | 134 +++++++++++++
 tb/tb_queue_enq_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/queue_enq_arbiter.sv
// rtl/queue_enq_arbiter.sv - round-robin enqueue arbiter, dequeue gate and flush sequencer for one circular queue
// Optional stall statistics counter enabled by defining QARB_STALL_STATS_EN.
module queue_enq_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int SIZE    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       deq_req,
  output logic                       deq_valid,
  input  logic                       flush,
  output logic                       q_enq,
  output logic                       q_deq,
  output logic [WIDTH-1:0]           q_in,
  output logic                       q_flush,
  output logic [$clog2(SIZE):0]      count,
  output logic                       busy
`ifdef QARB_STALL_STATS_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            deq_valid_q, deq_valid_d;
  logic            can_enq;
  logic            found;
  int              tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      deq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      deq_valid_q <= deq_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    count_d     = count_q;
    deq_valid_d = 1'b0;
    gnt         = '0;
    q_enq       = 1'b0;
    q_deq       = 1'b0;
    q_in        = '0;
    q_flush     = 1'b0;
    busy        = 1'b0;
    can_enq     = 1'b0;
    found       = 1'b0;
    tgt         = 0;

    if (state_q == S_FLUSH) begin
      q_flush     = 1'b1;
      busy        = 1'b1;
      count_d     = '0;
      deq_valid_d = 1'b0;
      state_d     = S_RUN;
    end else begin
      q_deq   = deq_req && (count_q != '0);
      // A full queue can still accept when the same edge frees a slot.
      can_enq = (count_q < SIZE_C) || ((count_q == SIZE_C) && q_deq);

      if (can_enq) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          tgt = int'(rr_ptr_q) + k;
          if (tgt >= NUM_REQ) tgt = tgt - NUM_REQ;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i == tgt) && req[i]) begin
              found    = 1'b1;
              gnt[i]   = 1'b1;
              q_in     = req_data[i*WIDTH +: WIDTH];
              rr_ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
          end
        end
      end

      q_enq       = found;
      deq_valid_d = q_deq;

      case ({q_enq, q_deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (flush) state_d = S_FLUSH;
    end
  end

  assign count     = count_q;
  assign deq_valid = deq_valid_q;

`ifdef QARB_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Flush does not clear the statistic; only reset does.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_RUN) && (|req) && !can_enq && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// tb/tb_queue_enq_arbiter.sv - scoreboard bench for queue_enq_arbiter with directed vectors
module tb_queue_enq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [127:0] req_data;
  logic [3:0]  gnt;
  logic        deq_req;
  logic        deq_valid;
  logic        flush;
  logic        q_enq;
  logic        q_deq;
  logic [31:0] q_in;
  logic        q_flush;
  logic [3:0]  count;
  logic        busy;
`ifdef QARB_STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       deq;
    logic       fl;
    logic [3:0] cnt;
    logic       dv;
    int         stall;
  } exp_t;

  exp_t sb[$];

  queue_enq_arbiter #(.WIDTH(32), .NUM_REQ(4), .SIZE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .deq_req   (deq_req),
    .deq_valid (deq_valid),
    .flush     (flush),
    .q_enq     (q_enq),
    .q_deq     (q_deq),
    .q_in      (q_in),
    .q_flush   (q_flush),
    .count     (count),
    .busy      (busy)
`ifdef QARB_STALL_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [3:0] g);
    case (g)
      4'b0001: return 32'hD0D0_0000;
      4'b0010: return 32'hD0D0_0001;
      4'b0100: return 32'hD0D0_0002;
      4'b1000: return 32'hD0D0_0003;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per driven cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt",       32'(gnt),       32'(e.gnt));
        chk("q_enq",     32'(q_enq),     32'(|e.gnt));
        chk("q_in",      q_in,           data_of(e.gnt));
        chk("q_deq",     32'(q_deq),     32'(e.deq));
        chk("q_flush",   32'(q_flush),   32'(e.fl));
        chk("busy",      32'(busy),      32'(e.fl));
        chk("count",     32'(count),     32'(e.cnt));
        chk("deq_valid", 32'(deq_valid), 32'(e.dv));
`ifdef QARB_STALL_STATS_EN
        if (e.stall >= 0) chk("stall_cnt", stall_cnt, 32'(e.stall));
`endif
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic d, input logic f,
                      input logic [3:0] eg, input logic ed, input logic efl,
                      input logic [3:0] ec, input logic edv, input int es);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = r;
    req     = rq;
    deq_req = d;
    flush   = f;
    e.gnt = eg; e.deq = ed; e.fl = efl; e.cnt = ec; e.dv = edv; e.stall = es;
    sb.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hD0D0_0000 | 32'(i);
    rst = 1'b1; req = '0; deq_req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'd0, 0, 0);

    // round-robin fairness until full
    for (int c = 0; c < 8; c++)
      step(0, 4'hF, 0, 0, 4'(1 << (c % 4)), 0, 0, 4'(c), 0, 0);
    step(0, 4'hF, 0, 0, 4'h0, 0, 0, 4'd8, 0, 0);

    // full boundary: simultaneous enq and deq at count==8
    step(0, 4'b0100, 1, 0, 4'b0100, 1, 0, 4'd8, 0, 1);
    step(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'd8, 1, 1);

    // drain to empty, then empty boundary
    for (int i = 0; i < 8; i++)
      step(0, 4'h0, 1, 0, 4'h0, 1, 0, 4'(8 - i), (i != 0), 1);
    step(0, 4'h0, 1, 0, 4'h0, 0, 0, 4'd0, 1, 1);
    step(0, 4'h0, 1, 0, 4'h0, 0, 0, 4'd0, 0, 1);
    step(0, 4'b0001, 1, 0, 4'b0001, 0, 0, 4'd0, 0, 1);

    // flush mid-stream at count 5
    for (int i = 0; i < 4; i++)
      step(0, 4'b0001, 0, 0, 4'b0001, 0, 0, 4'(1 + i), 0, 1);
    step(0, 4'b0010, 0, 1, 4'b0010, 0, 0, 4'd5, 0, 1);
    step(0, 4'hF, 1, 0, 4'h0, 0, 1, 4'd6, 0, 1);
    step(0, 4'hF, 0, 0, 4'b0100, 0, 0, 4'd0, 0, 1);

    // reset mid-operation at count 6, rr_ptr 3
    for (int i = 0; i < 5; i++)
      step(0, 4'b0100, 0, 0, 4'b0100, 0, 0, 4'(1 + i), 0, 1);
    step(1, 4'b1001, 0, 0, 4'b1000, 0, 0, 4'd6, 0, 1);
    step(0, 4'b1001, 0, 0, 4'b0001, 0, 0, 4'd0, 0, 0);

    // fill, stall for 10 cycles, then flush
    for (int i = 0; i < 7; i++)
      step(0, 4'b0001, 0, 0, 4'b0001, 0, 0, 4'(1 + i), 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 4'b0001, 0, 0, 4'h0, 0, 0, 4'd8, 0, i);
    step(0, 4'h0, 0, 1, 4'h0, 0, 0, 4'd8, 0, 10);
    step(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'd8, 0, 10);
    step(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'd0, 0, 10);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d records unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
